ch0re_pipe_ctrl: RTL and testbench

Parametrised pipeline control block for the ch0re in-order RV64I core. It owns the PC register and the per-stage valid/rd/wen/load scoreboard. It produces the stage enables, flushes and load-use stalls, the EX-operand forwarding selects, the ID-stage write-back bypass and the retired-instruction counter. The surrounding datapath keeps all payload data (operands, results, immediates) and steers its muxes and register enables from this block's outputs.

---
 rtl/ch0re_pipe_ctrl_if.sv | 47 ++++
 rtl/ch0re_pipe_ctrl.sv | 141 ++++++++++++++
 tb/tb_ch0re_pipe_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ch0re_pipe_ctrl_if.sv
// Bundle between the ch0re datapath and its pipeline control block.
// The datapath drives decode, redirect and freeze information (master); the control block answers with enables and selects (slave).
interface ch0re_pipe_ctrl_if #(
   parameter int XLEN    = 64,
   parameter int RADDR_W = 5,
   parameter int NSTAGES = 5,
   parameter int SELW    = $clog2(NSTAGES)
);
   logic                 i_freeze;
   logic [RADDR_W-1:0]   i_id_rs1;
   logic [RADDR_W-1:0]   i_id_rs2;
   logic                 i_id_use_rs1;
   logic                 i_id_use_rs2;
   logic [RADDR_W-1:0]   i_id_rd;
   logic                 i_id_wen;
   logic                 i_id_is_load;
   logic                 i_redirect;
   logic [XLEN-1:0]      i_redirect_pc;

   logic [XLEN-1:0]      o_pc;
   logic [NSTAGES-1:0]   o_stage_en;
   logic [NSTAGES-2:0]   o_stage_valid;
   logic                 o_load_use_stall;
   logic [SELW-1:0]      o_fwd_sel_rs1;
   logic [SELW-1:0]      o_fwd_sel_rs2;
   logic                 o_id_bypass_rs1;
   logic                 o_id_bypass_rs2;
   logic                 o_rf_wen;
   logic [RADDR_W-1:0]   o_rf_waddr;
   logic [63:0]          o_instret;

   modport master (
      output i_freeze, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
             i_id_rd, i_id_wen, i_id_is_load, i_redirect, i_redirect_pc,
      input  o_pc, o_stage_en, o_stage_valid, o_load_use_stall,
             o_fwd_sel_rs1, o_fwd_sel_rs2, o_id_bypass_rs1, o_id_bypass_rs2,
             o_rf_wen, o_rf_waddr, o_instret
   );

   modport slave (
      input  i_freeze, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
             i_id_rd, i_id_wen, i_id_is_load, i_redirect, i_redirect_pc,
      output o_pc, o_stage_en, o_stage_valid, o_load_use_stall,
             o_fwd_sel_rs1, o_fwd_sel_rs2, o_id_bypass_rs1, o_id_bypass_rs2,
             o_rf_wen, o_rf_waddr, o_instret
   );
endinterface

// File: rtl/ch0re_pipe_ctrl.sv
// Pipeline control for the ch0re in-order RV64I core.
// It owns the PC and the per-stage hazard scoreboard; the datapath keeps all payload data.
module ch0re_pipe_ctrl #(
   parameter int              NSTAGES    = 5,
   parameter int              XLEN       = 64,
   parameter int              RADDR_W    = 5,
   parameter logic [XLEN-1:0] RESET_PC   = 'h150,
   parameter int              LOAD_READY = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   ch0re_pipe_ctrl_if.slave bus
);
   localparam int SELW = $clog2(NSTAGES);

   logic [XLEN-1:0]    pc_q;
   logic [63:0]        instret_q;
   logic [NSTAGES-1:1] valid_q;
   logic [RADDR_W-1:0] rd_q      [2:NSTAGES-1];
   logic               wen_q     [2:NSTAGES-1];
   logic               is_load_q [2:NSTAGES-1];
   logic [RADDR_W-1:0] ex_rs1_q;
   logic [RADDR_W-1:0] ex_rs2_q;
   logic               ex_use_rs1_q;
   logic               ex_use_rs2_q;

   logic [NSTAGES-1:2] writer;
   logic               load_use;
   logic               redirect_go;
   logic [SELW-1:0]    fwd_sel_rs1;
   logic [SELW-1:0]    fwd_sel_rs2;
   logic               fwd_load_rs1;
   logic               fwd_load_rs2;

   // R[1] carries only a valid bit: its rd/wen/load are decoded from its payload and arrive on i_id_*.
   always_comb begin
      writer = '0;
      for (int k = 2; k < NSTAGES; k++) begin
         writer[k] = valid_q[k] & wen_q[k] & (rd_q[k] != '0);
      end
   end

   // Loads still short of LOAD_READY cannot be forwarded, so a dependent ID instruction waits.
   always_comb begin
      load_use = 1'b0;
      for (int k = 2; k <= LOAD_READY - 2; k++) begin
         if (writer[k] && is_load_q[k] &&
             ((bus.i_id_use_rs1 && rd_q[k] == bus.i_id_rs1) ||
              (bus.i_id_use_rs2 && rd_q[k] == bus.i_id_rs2))) begin
            load_use = valid_q[1];
         end
      end
   end

   assign redirect_go = bus.i_redirect & ~bus.i_freeze;

   always_comb begin
      bus.o_stage_en = '1;
      if (bus.i_freeze) begin
         bus.o_stage_en = '0;
      end else if (!bus.i_redirect && load_use) begin
         bus.o_stage_en[1:0] = 2'b00;
      end
   end

   // Scanning from the oldest stage down leaves the youngest matching writer selected.
   always_comb begin
      fwd_sel_rs1  = '0;
      fwd_sel_rs2  = '0;
      fwd_load_rs1 = 1'b0;
      fwd_load_rs2 = 1'b0;
      for (int k = NSTAGES - 1; k >= 3; k--) begin
         if (valid_q[2] && ex_use_rs1_q && writer[k] && rd_q[k] == ex_rs1_q) begin
            fwd_sel_rs1  = SELW'(k);
            fwd_load_rs1 = is_load_q[k] && (k < LOAD_READY);
         end
         if (valid_q[2] && ex_use_rs2_q && writer[k] && rd_q[k] == ex_rs2_q) begin
            fwd_sel_rs2  = SELW'(k);
            fwd_load_rs2 = is_load_q[k] && (k < LOAD_READY);
         end
      end
   end

   assert property (@(posedge clk) disable iff (!rst_n) !(fwd_load_rs1 || fwd_load_rs2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         instret_q    <= '0;
         valid_q      <= '0;
         ex_rs1_q     <= '0;
         ex_rs2_q     <= '0;
         ex_use_rs1_q <= 1'b0;
         ex_use_rs2_q <= 1'b0;
         for (int k = 2; k < NSTAGES; k++) begin
            rd_q[k]      <= '0;
            wen_q[k]     <= 1'b0;
            is_load_q[k] <= 1'b0;
         end
      end else if (!bus.i_freeze) begin
         instret_q <= instret_q + 64'(valid_q[NSTAGES-1]);
         for (int k = 3; k < NSTAGES; k++) begin
            valid_q[k]   <= valid_q[k-1];
            rd_q[k]      <= rd_q[k-1];
            wen_q[k]     <= wen_q[k-1];
            is_load_q[k] <= is_load_q[k-1];
         end
         if (redirect_go) begin
            pc_q       <= bus.i_redirect_pc;
            valid_q[1] <= 1'b0;
            valid_q[2] <= 1'b0;
         end else if (load_use) begin
            valid_q[2] <= 1'b0;
         end else begin
            pc_q         <= pc_q + XLEN'(4);
            valid_q[1]   <= 1'b1;
            valid_q[2]   <= valid_q[1];
            rd_q[2]      <= bus.i_id_rd;
            wen_q[2]     <= bus.i_id_wen;
            is_load_q[2] <= bus.i_id_is_load;
            ex_rs1_q     <= bus.i_id_rs1;
            ex_rs2_q     <= bus.i_id_rs2;
            ex_use_rs1_q <= bus.i_id_use_rs1;
            ex_use_rs2_q <= bus.i_id_use_rs2;
         end
      end
   end

   assign bus.o_pc             = pc_q;
   assign bus.o_instret        = instret_q;
   assign bus.o_stage_valid    = valid_q;
   assign bus.o_load_use_stall = load_use;
   assign bus.o_fwd_sel_rs1    = fwd_sel_rs1;
   assign bus.o_fwd_sel_rs2    = fwd_sel_rs2;
   assign bus.o_id_bypass_rs1  = writer[NSTAGES-1] & valid_q[1] & bus.i_id_use_rs1 &
                                 (rd_q[NSTAGES-1] == bus.i_id_rs1);
   assign bus.o_id_bypass_rs2  = writer[NSTAGES-1] & valid_q[1] & bus.i_id_use_rs2 &
                                 (rd_q[NSTAGES-1] == bus.i_id_rs2);
   assign bus.o_rf_wen         = writer[NSTAGES-1] & ~bus.i_freeze;
   assign bus.o_rf_waddr       = rd_q[NSTAGES-1];
endmodule

// File: tb/tb_ch0re_pipe_ctrl.sv
// Scoreboard bench for ch0re_pipe_ctrl: directed instruction streams push hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_ch0re_pipe_ctrl;
   localparam int NSTAGES = 5;
   localparam int XLEN    = 64;
   localparam int RADDR_W = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ch0re_pipe_ctrl_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .NSTAGES(NSTAGES)) bus ();

   ch0re_pipe_ctrl #(
      .NSTAGES(NSTAGES), .XLEN(XLEN), .RADDR_W(RADDR_W),
      .RESET_PC(64'h150), .LOAD_READY(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic [RADDR_W-1:0] rs1, rs2, rd;
      logic               use1, use2, wen, load;
   } id_t;

   typedef enum int {F_PC, F_VALID, F_EN, F_STALL, F_FWD1, F_FWD2,
                     F_BYP1, F_BYP2, F_RFWEN, F_WADDR, F_INSTRET} fld_t;

   typedef struct {
      int          tick;
      fld_t        fld;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   tick     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic id_t ins(input int rd, wen, rs1, u1, rs2, u2, ld);
      id_t r;
      r.rd   = RADDR_W'(rd);
      r.wen  = (wen != 0);
      r.rs1  = RADDR_W'(rs1);
      r.use1 = (u1 != 0);
      r.rs2  = RADDR_W'(rs2);
      r.use2 = (u2 != 0);
      r.load = (ld != 0);
      return r;
   endfunction

   function automatic id_t nop();
      return ins(0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic logic [63:0] actual(input fld_t f);
      case (f)
         F_PC:      return bus.o_pc;
         F_VALID:   return 64'(bus.o_stage_valid);
         F_EN:      return 64'(bus.o_stage_en);
         F_STALL:   return 64'(bus.o_load_use_stall);
         F_FWD1:    return 64'(bus.o_fwd_sel_rs1);
         F_FWD2:    return 64'(bus.o_fwd_sel_rs2);
         F_BYP1:    return 64'(bus.o_id_bypass_rs1);
         F_BYP2:    return 64'(bus.o_id_bypass_rs2);
         F_RFWEN:   return 64'(bus.o_rf_wen);
         F_WADDR:   return 64'(bus.o_rf_waddr);
         F_INSTRET: return bus.o_instret;
         default:   return 64'hdead;
      endcase
   endfunction

   task automatic expect_val(input fld_t f, input logic [63:0] v);
      exp_t e;
      e.tick = tick;
      e.fld  = f;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic check_output(input exp_t e);
      logic [63:0] act;
      act = actual(e.fld);
      n_checks++;
      if (act !== e.val) begin
         n_fail++;
         $display("[TB] FAIL %s at tick %0d: got 0x%0h, expected 0x%0h",
                  e.fld.name(), e.tick, act, e.val);
      end
   endtask

   task automatic drive(input id_t id, input logic redir, input logic frz);
      bus.i_id_rs1      = id.rs1;
      bus.i_id_rs2      = id.rs2;
      bus.i_id_use_rs1  = id.use1;
      bus.i_id_use_rs2  = id.use2;
      bus.i_id_rd       = id.rd;
      bus.i_id_wen      = id.wen;
      bus.i_id_is_load  = id.load;
      bus.i_redirect    = redir;
      bus.i_redirect_pc = 64'h400;
      bus.i_freeze      = frz;
   endtask

   task automatic apply_stimulus(input id_t id, input logic redir, input logic frz);
      @(posedge clk);
      #1;
      tick++;
      drive(id, redir, frz);
   endtask

   task automatic step(input id_t id);
      apply_stimulus(id, 1'b0, 1'b0);
   endtask

   // Reset is asserted between edges so the checked reset state can only come from the async path.
   task automatic do_reset();
      @(posedge clk);
      #1;
      tick++;
      rst_n = 1'b0;
      drive(nop(), 1'b0, 1'b0);
      #1;
      expect_val(F_PC, 64'h150);
      expect_val(F_VALID, 0);
      expect_val(F_INSTRET, 0);
      expect_val(F_EN, 64'h1f);
      expect_val(F_STALL, 0);
      expect_val(F_FWD1, 0);
      expect_val(F_FWD2, 0);
      expect_val(F_BYP1, 0);
      expect_val(F_BYP2, 0);
      expect_val(F_RFWEN, 0);
      #5;
      rst_n = 1'b1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].tick <= tick) begin
            e = sb.pop_front();
            if (e.tick < tick) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL stale_%s: expectation for tick %0d unchecked at tick %0d, value 0x%0h",
                        e.fld.name(), e.tick, tick, e.val);
            end else begin
               check_output(e);
            end
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      drive(nop(), 1'b0, 1'b0);

      $display("[TB] free-running fill");
      do_reset();
      for (int c = 1; c <= 6; c++) begin
         step(nop());
         expect_val(F_PC, 64'h150 + 64'(4 * c));
         expect_val(F_VALID, (c <= 4) ? 64'((1 << c) - 1) : 64'hf);
         expect_val(F_EN, 64'h1f);
         if (c >= 4) expect_val(F_INSTRET, 64'(c - 4));
      end

      $display("[TB] ALU forwarding");
      do_reset();
      step(ins(5, 1, 0, 0, 0, 0, 0));
      expect_val(F_VALID, 1);
      step(ins(6, 1, 5, 1, 0, 0, 0));
      expect_val(F_STALL, 0); expect_val(F_FWD1, 0);
      step(ins(11, 1, 5, 1, 6, 1, 0));
      expect_val(F_FWD1, 3); expect_val(F_FWD2, 0); expect_val(F_STALL, 0); expect_val(F_EN, 64'h1f);
      step(ins(0, 0, 5, 1, 0, 0, 0));
      expect_val(F_FWD1, 4); expect_val(F_FWD2, 3); expect_val(F_BYP1, 1); expect_val(F_BYP2, 0);
      expect_val(F_RFWEN, 1); expect_val(F_WADDR, 5);
      step(nop());
      expect_val(F_FWD1, 0); expect_val(F_BYP1, 0); expect_val(F_RFWEN, 1); expect_val(F_WADDR, 6);
      expect_val(F_INSTRET, 1);
      step(nop());
      expect_val(F_RFWEN, 1); expect_val(F_WADDR, 11); expect_val(F_INSTRET, 2);
      step(nop());
      expect_val(F_RFWEN, 0); expect_val(F_INSTRET, 3);

      $display("[TB] load-use stall");
      do_reset();
      step(ins(7, 1, 0, 0, 0, 0, 1));
      expect_val(F_STALL, 0);
      step(ins(8, 1, 7, 1, 0, 0, 0));
      expect_val(F_STALL, 1); expect_val(F_EN, 64'h1c); expect_val(F_PC, 64'h158); expect_val(F_VALID, 3);
      step(ins(8, 1, 7, 1, 0, 0, 0));
      expect_val(F_STALL, 0); expect_val(F_EN, 64'h1f); expect_val(F_PC, 64'h158);
      expect_val(F_VALID, 4'b0101); expect_val(F_FWD1, 0);
      step(nop());
      expect_val(F_PC, 64'h15c); expect_val(F_VALID, 4'b1011); expect_val(F_FWD1, 4);
      expect_val(F_RFWEN, 1); expect_val(F_WADDR, 7);
      step(nop());
      expect_val(F_VALID, 4'b0111); expect_val(F_RFWEN, 0); expect_val(F_INSTRET, 1);

      $display("[TB] redirect over load-use");
      do_reset();
      step(ins(7, 1, 0, 0, 0, 0, 1));
      apply_stimulus(ins(8, 1, 7, 1, 0, 0, 0), 1'b1, 1'b0);
      expect_val(F_EN, 64'h1f); expect_val(F_PC, 64'h158);
      step(nop());
      expect_val(F_PC, 64'h400); expect_val(F_VALID, 4'b0100); expect_val(F_STALL, 0);
      step(nop());
      expect_val(F_PC, 64'h404); expect_val(F_VALID, 4'b1001); expect_val(F_INSTRET, 0);
      expect_val(F_RFWEN, 1); expect_val(F_WADDR, 7);
      step(nop());
      expect_val(F_VALID, 4'b0011); expect_val(F_INSTRET, 1); expect_val(F_RFWEN, 0);
      step(nop());
      expect_val(F_VALID, 4'b0111); expect_val(F_INSTRET, 1);
      step(nop());
      expect_val(F_VALID, 4'b1111); expect_val(F_INSTRET, 1);
      step(nop());
      expect_val(F_INSTRET, 2);

      $display("[TB] freeze with pending redirect");
      do_reset();
      for (int c = 1; c <= 4; c++) step(ins(c, 1, 0, 0, 0, 0, 0));
      expect_val(F_PC, 64'h160); expect_val(F_VALID, 4'hf);
      apply_stimulus(ins(5, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1);
      expect_val(F_PC, 64'h164); expect_val(F_VALID, 4'hf); expect_val(F_INSTRET, 1);
      expect_val(F_EN, 0); expect_val(F_RFWEN, 0); expect_val(F_WADDR, 2);
      apply_stimulus(ins(5, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1);
      expect_val(F_PC, 64'h164); expect_val(F_INSTRET, 1); expect_val(F_EN, 0);
      expect_val(F_RFWEN, 0); expect_val(F_VALID, 4'hf);
      apply_stimulus(ins(5, 1, 0, 0, 0, 0, 0), 1'b1, 1'b1);
      expect_val(F_PC, 64'h164); expect_val(F_INSTRET, 1); expect_val(F_EN, 0); expect_val(F_WADDR, 2);
      apply_stimulus(ins(5, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0);
      expect_val(F_PC, 64'h164); expect_val(F_RFWEN, 1); expect_val(F_WADDR, 2);
      expect_val(F_EN, 64'h1f); expect_val(F_INSTRET, 1);
      step(nop());
      expect_val(F_PC, 64'h400); expect_val(F_INSTRET, 2); expect_val(F_WADDR, 3);
      expect_val(F_VALID, 4'b1100);
      step(nop());
      expect_val(F_PC, 64'h404); expect_val(F_WADDR, 4); expect_val(F_RFWEN, 1); expect_val(F_INSTRET, 3);

      $display("[TB] x0 destination and write-back bypass");
      do_reset();
      step(ins(0, 1, 0, 0, 0, 0, 0));
      step(ins(12, 1, 0, 1, 0, 0, 0));
      step(ins(9, 1, 0, 0, 0, 0, 0));
      expect_val(F_FWD1, 0);
      step(nop());
      expect_val(F_RFWEN, 0); expect_val(F_WADDR, 0);
      step(ins(13, 1, 9, 1, 0, 0, 0));
      expect_val(F_BYP1, 0); expect_val(F_RFWEN, 1); expect_val(F_WADDR, 12);
      step(ins(0, 0, 9, 1, 9, 0, 0));
      expect_val(F_BYP1, 1); expect_val(F_BYP2, 0); expect_val(F_RFWEN, 1);
      expect_val(F_WADDR, 9); expect_val(F_FWD1, 4);
      step(nop());
      expect_val(F_BYP1, 0);

      @(negedge clk);
      #2;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
